// File: rtl/spart_rx.sv
// spart_rx: 16x-oversampled 8N1 serial receiver with data-available, framing-error and overrun status
module spart_rx #(
  parameter int DATA_BITS = 8,
  parameter int OVERSAMPLE = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_enable,
  input  logic                 rxd,
  input  logic                 rd_ack,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rda,
  output logic                 framing_err,
  output logic                 overrun
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic [TW-1:0] tick_cnt, tick_n;
  logic [BW-1:0] bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shift, shift_n, data_n;
  logic armed, armed_n, rda_n, fe_n, ov_n, rxd_s;
  assign rxd_s = sync[SYNC_STAGES-1];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sync <= '1;
      state <= IDLE;
      tick_cnt <= '0;
      bit_cnt <= '0;
      shift <= '0;
      armed <= 1'b0;
      data_out <= '0;
      rda <= 1'b0;
      framing_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], rxd};
      state <= state_n;
      tick_cnt <= tick_n;
      bit_cnt <= bit_n;
      shift <= shift_n;
      armed <= armed_n;
      data_out <= data_n;
      rda <= rda_n;
      framing_err <= fe_n;
      overrun <= ov_n;
    end
  always_comb begin
    state_n = state;
    tick_n = tick_cnt;
    bit_n = bit_cnt;
    shift_n = shift;
    armed_n = armed;
    data_n = data_out;
    rda_n = rd_ack ? 1'b0 : rda;
    fe_n = rd_ack ? 1'b0 : framing_err;
    ov_n = rd_ack ? 1'b0 : overrun;
    if (rx_enable)
      case (state)
        IDLE: begin
          armed_n = rxd_s;
          tick_n = '0;
          state_n = (armed && !rxd_s) ? START : IDLE;
        end
        START: begin
          tick_n = tick_cnt + 1'b1;
          if (tick_n == HALF_LAST) begin
            state_n = rxd_s ? IDLE : DATA;
            tick_n = '0;
            bit_n = '0;
          end
        end
        DATA: begin
          tick_n = tick_cnt + 1'b1;
          if (tick_cnt == BIT_LAST) begin
            tick_n = '0;
            shift_n = {rxd_s, shift[DATA_BITS-1:1]};
            bit_n = bit_cnt + 1'b1;
            state_n = (bit_cnt == DATA_LAST) ? STOP : DATA;
          end
        end
        STOP: begin
          tick_n = tick_cnt + 1'b1;
          if (tick_cnt == BIT_LAST) begin
            state_n = IDLE;
            tick_n = '0;
            data_n = shift;
            rda_n = 1'b1;
            fe_n = ~rxd_s;
            ov_n = rda & ~rd_ack;
          end
        end
        default: state_n = IDLE;
      endcase
  end
endmodule

// File: tb/tb_spart_rx.sv
// tb_spart_rx: frame-level reference model driving randomized 8N1 traffic into spart_rx
module tb_spart_rx;
  localparam int OS = 16;
  localparam int NB = 8;
  localparam int SS = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx_enable = 1'b0;
  logic rxd = 1'b1;
  logic rd_ack = 1'b0;
  logic [NB-1:0] data_out;
  logic rda, framing_err, overrun;
  int checks = 0;
  int failures = 0;
  int div = 4;
  logic [NB-1:0] exp_data = '0;
  logic exp_rda = 1'b0;
  logic exp_fe = 1'b0;
  logic exp_ov = 1'b0;
  spart_rx #(.DATA_BITS(NB), .OVERSAMPLE(OS), .SYNC_STAGES(SS)) dut (
    .clk(clk),
    .rst(rst),
    .rx_enable(rx_enable),
    .rxd(rxd),
    .rd_ack(rd_ack),
    .data_out(data_out),
    .rda(rda),
    .framing_err(framing_err),
    .overrun(overrun)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic check_outputs(input string tag);
    check({tag, ".data"}, 32'(data_out), 32'(exp_data));
    check({tag, ".rda"}, 32'(rda), 32'(exp_rda));
    check({tag, ".fe"}, 32'(framing_err), 32'(exp_fe));
    check({tag, ".ov"}, 32'(overrun), 32'(exp_ov));
  endtask
  task automatic do_tick(input logic v, input bit ack);
    repeat (div - 1) begin
      @(negedge clk);
      rx_enable = 1'b0;
      rd_ack = 1'b0;
    end
    @(negedge clk);
    rx_enable = 1'b1;
    rd_ack = ack;
    rxd = v;
  endtask
  task automatic settle();
    @(negedge clk);
    rx_enable = 1'b0;
    rd_ack = 1'b0;
  endtask
  task automatic line(input logic v, input int n);
    for (int i = 0; i < n; i++) do_tick(v, 1'b0);
    settle();
  endtask
  task automatic ack();
    @(negedge clk);
    rx_enable = 1'b0;
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    exp_rda = 1'b0;
    exp_fe = 1'b0;
    exp_ov = 1'b0;
  endtask
  task automatic send_frame(input logic [NB-1:0] b, input logic stop, input bit ack_done, input int abort_at = -1);
    int d, c, idx;
    logic [NB+1:0] frame;
    d = (SS + div - 1) / div;
    c = d + OS / 2 - 1 + OS * (NB + 1);
    frame = {stop, b, 1'b0};
    for (int i = 0; i < NB + 2; i++)
      for (int t = 0; t < OS; t++) begin
        idx = i * OS + t;
        do_tick(frame[i], ack_done && idx == c);
        if (idx == abort_at) begin
          #1 rst = 1'b0;
          #1;
          exp_data = '0;
          exp_rda = 1'b0;
          exp_fe = 1'b0;
          exp_ov = 1'b0;
          check_outputs("reset_mid");
          rx_enable = 1'b0;
          rd_ack = 1'b0;
          rxd = 1'b0;
          repeat (3) @(negedge clk);
          rst = 1'b1;
          repeat (4) @(negedge clk);
          return;
        end
      end
    settle();
    exp_data = b;
    exp_ov = exp_rda && !ack_done;
    exp_rda = 1'b1;
    exp_fe = !stop;
  endtask
  initial begin
    logic [NB-1:0] b;
    logic stop;
    bit ackd;
    repeat (3) @(negedge clk);
    check_outputs("reset");
    rst = 1'b1;
    line(1'b1, 4);
    send_frame(8'hA5, 1'b1, 1'b0);
    check_outputs("nominal");
    ack();
    check_outputs("nominal_ack");
    line(1'b0, 3);
    line(1'b1, 20);
    check_outputs("false_start");
    send_frame(8'h3C, 1'b1, 1'b0);
    check_outputs("after_glitch");
    ack();
    line(1'b1, 2);
    send_frame(8'h81, 1'b0, 1'b0);
    check_outputs("framing");
    ack();
    line(1'b0, 40 * OS);
    check_outputs("break_hold");
    line(1'b1, 4);
    send_frame(8'h7E, 1'b1, 1'b0);
    check_outputs("after_break");
    ack();
    line(1'b1, 2);
    send_frame(8'h11, 1'b1, 1'b0);
    line(1'b1, 2);
    send_frame(8'h22, 1'b1, 1'b0);
    check_outputs("overrun");
    ack();
    line(1'b1, 2);
    send_frame(8'h11, 1'b1, 1'b0);
    line(1'b1, 2);
    send_frame(8'h22, 1'b1, 1'b1);
    check_outputs("collision");
    ack();
    line(1'b1, 2);
    send_frame(8'h33, 1'b1, 1'b0);
    line(1'b1, 2);
    send_frame(8'hF0, 1'b1, 1'b0, 5 * OS + 4);
    line(1'b0, 40);
    check_outputs("post_reset_low");
    line(1'b1, 4);
    send_frame(8'h5A, 1'b1, 1'b0);
    check_outputs("post_reset");
    ack();
    div = 1;
    line(1'b1, 4);
    for (int i = 0; i < 3; i++) begin
      b = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : 8'h55;
      send_frame(b, 1'b1, 1'b0);
      check_outputs("stream");
      ack();
      line(1'b1, 1);
    end
    for (int n = 0; n < 30; n++) begin
      div = int'($urandom_range(1, 4));
      b = NB'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      ackd = ($urandom_range(0, 3) == 0);
      send_frame(b, stop, ackd);
      check_outputs("rand");
      if ($urandom_range(0, 1) == 1) begin
        ack();
        check_outputs("rand_ack");
      end
      line(1'b1, int'($urandom_range(1, 4)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/spart_rx.md
Name: spart_rx

Overview:
- SPART serial receiver; the consumer end of the baud generator's rx_enable tick.
- Samples the asynchronous RxD line with 16x oversampling and deframes 8N1 characters (start, 8 data bits LSB first, 1 stop).
- Presents each received byte to the bus interface with a receive-data-available flag, plus framing-error and overrun status.

Parameters:
- DATA_BITS, 8, data bits per character.
- OVERSAMPLE, 16, rx_enable ticks per bit period. Must be even and at least 4.
- SYNC_STAGES, 2, flops in the RxD synchronizer. Must be at least 2.

Ports:
- clk  in  1  system clock, same as the baud generator clock.
- rst  in  1  asynchronous, active-low reset: asserted when low; takes effect immediately without a clock edge.
- rx_enable  in  1  one-clk-wide oversample tick (OVERSAMPLE per bit).
- rxd  in  1  serial input, idle high, asynchronous to clk.
- rd_ack  in  1  one-clk strobe: bus has read data_out.
- data_out  out  DATA_BITS  last received byte.
- rda  out  1  receive data available.
- framing_err  out  1  stop bit of the byte in data_out sampled low.
- overrun  out  1  a byte completed while rda was still set.

Behaviour:
- Reset (rst low): all outputs are 0. Synchronizer flops are 1. FSM goes to IDLE, tick counter and bit counter are 0, shift register is 0, armed is 0.
- Synchronizer: rxd passes through SYNC_STAGES flops to give rxd_s. All decisions use rxd_s.
- All FSM activity advances only on clk edges where rx_enable=1. Other cycles hold state, except rd_ack handling.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - Tick with rxd_s=1 sets armed=1.
  - Tick with armed=1 and rxd_s=0 goes to START, with tick_cnt=0 and armed=0.
  - A line held low after a break therefore cannot retrigger.
- START:
  - tick_cnt increments each tick.
  - At the tick where tick_cnt reaches OVERSAMPLE/2-1 (mid-bit), sample rxd_s.
  - Sample 0: go to DATA, tick_cnt=0, bit_cnt=0.
  - Sample 1: false start, go to IDLE.
- DATA:
  - tick_cnt counts 0..OVERSAMPLE-1 and wraps.
  - At each wrap (tick OVERSAMPLE-1), shift rxd_s into the MSB of the shift register (right shift, so the first bit lands in bit 0 after DATA_BITS shifts) and increment bit_cnt.
  - After the DATA_BITS-th sample, go to STOP with tick_cnt=0.
- STOP: at tick OVERSAMPLE-1, sample the stop bit, then complete the byte and go to IDLE.
- Byte completion, registered on that same clk edge:
  - data_out <= shift register; rda <= 1.
  - framing_err <= ~stop_sample.
  - overrun <= 1 if rda was 1 and no rd_ack this cycle, else 0.
  - data_out is overwritten on overrun: newest byte wins.
- rd_ack with no completion in the same cycle: rda, framing_err and overrun clear to 0 on the next edge. data_out holds.
- rd_ack coinciding with completion: completion wins. rda=1, overrun=0, framing_err from the new stop bit.
- rd_ack while rda=0: no effect.
- Timing: with start detected at tick T0, data bit k is sampled at tick T0+OVERSAMPLE/2+OVERSAMPLE*(k+1)-1. Outputs update on the clk edge of the stop-sample tick and are visible the following cycle.
- rx_enable held high every cycle is legal; the block then degenerates to a clk-based oversampler.
- Reset asserted mid-frame aborts the frame immediately. No partial byte is delivered. After release, armed=0, so a line currently low is ignored until seen high.
- Counter widths: tick_cnt is ceil(log2(OVERSAMPLE)) bits; bit_cnt is ceil(log2(DATA_BITS+1)) bits.

Test Plan:
- Nominal byte: rx_enable every 4 clks (bit = 64 clks); send 0xA5 framed 0,1,0,1,0,0,1,0,1,1 -> data_out=0xA5, rda=1, framing_err=0, overrun=0. rd_ack -> rda=0 next cycle, data_out stays 0xA5.
- False start: 3-tick low glitch on idle line -> FSM returns to IDLE, rda stays 0. A following valid 0x3C is then received correctly.
- Framing error: send 0x81 with stop bit 0 -> data_out=0x81, rda=1, framing_err=1. Line then held low 40 bit times -> no new rda until line returns high and a fresh start arrives.
- Overrun and collision:
  - Send 0x11 then 0x22 back-to-back with no rd_ack -> data_out=0x22, overrun=1.
  - Repeat with rd_ack on the exact completion cycle of 0x22 -> rda=1, overrun=0.
- Reset mid-frame: drop rst low during data bit 4 of 0xF0 -> all outputs 0 immediately. After release, with the line still low, nothing is received; then send 0x5A -> received correctly.
- Back-to-back stream: 0x00, 0xFF, 0x55 at max rate with rx_enable every clk, rd_ack after each byte -> each received byte is correct, no errors.
